// File: rtl/peak_detector.sv
// Peak detector for the solar-tracker calibration sweep.
// Tracks the largest ADC sample seen during a servo sweep and clears the
// max counter each time a new peak is captured. At end of sweep it turns
// the max counter around (MC=1), waits for the return run to finish and
// reports DONE, or flags ERR if the return never completes.
module peak_detector #(
    parameter int W           = 8,
    parameter int HYST        = 2,
    parameter int RET_TIMEOUT = 1023
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic         ADC_VALID,
    input  logic [W-1:0] ADC_DATA,
    input  logic         SWEEP_END,
    input  logic         CNT_RU,
    output logic         CNT_RST,
    output logic         MC,
    output logic [W-1:0] MAX_VAL,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);

    localparam int CW = $clog2(RET_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(RET_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SWEEP,
        RET_ARM,
        RET_WAIT,
        FIN
    } state_t;

    state_t        state;
    logic          first_sample;
    logic [CW-1:0] ret_cnt;
    logic [W:0]    threshold;
    logic          accept;

    // New-peak decision, evaluated one bit wider so MAX_VAL+HYST cannot wrap.
    always_comb begin
        threshold = {1'b0, MAX_VAL} + (W+1)'(HYST);
        accept    = ADC_VALID && (first_sample || ({1'b0, ADC_DATA} > threshold));
    end

    // Sweep / return controller with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            CNT_RST      <= 1'b0;
            MC           <= 1'b0;
            MAX_VAL      <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
            first_sample <= 1'b1;
            ret_cnt      <= '0;
        end else begin
            CNT_RST <= 1'b0;
            DONE    <= 1'b0;
            case (state)
                IDLE: begin
                    MC   <= 1'b0;
                    BUSY <= 1'b0;
                    if (START) begin
                        state        <= SWEEP;
                        MAX_VAL      <= '0;
                        first_sample <= 1'b1;
                        ERR          <= 1'b0;
                        CNT_RST      <= 1'b1;
                        BUSY         <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (accept) begin
                        MAX_VAL      <= ADC_DATA;
                        first_sample <= 1'b0;
                        CNT_RST      <= 1'b1;
                    end
                    // A peak landing on the SWEEP_END cycle pulses CNT_RST during
                    // RET_ARM, so MC waits one cycle there to keep the two apart.
                    if (SWEEP_END) begin
                        state <= RET_ARM;
                        MC    <= !accept;
                    end
                end
                RET_ARM: begin
                    MC      <= 1'b1;
                    ret_cnt <= '0;
                    state   <= RET_WAIT;
                end
                RET_WAIT: begin
                    if (!CNT_RU) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                        MC    <= 1'b0;
                    end else if (ret_cnt == TO_LAST) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                        MC    <= 1'b0;
                        ERR   <= 1'b1;
                    end else begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peak_detector.sv
// Testbench for peak_detector: each calibration session is scripted phase by
// phase, and the expected outputs for every cycle are derived from the
// sweep samples with plain integer arithmetic and queued for the checker.
module tb_peak_detector;

    localparam int W           = 8;
    localparam int HYST        = 2;
    localparam int RET_TIMEOUT = 15;

    logic         CLK       = 1'b0;
    logic         RESET     = 1'b1;
    logic         START     = 1'b0;
    logic         ADC_VALID = 1'b0;
    logic [W-1:0] ADC_DATA  = '0;
    logic         SWEEP_END = 1'b0;
    logic         CNT_RU    = 1'b0;
    logic         CNT_RST;
    logic         MC;
    logic [W-1:0] MAX_VAL;
    logic         BUSY;
    logic         DONE;
    logic         ERR;

    typedef struct {
        bit cnt_rst;
        bit mc;
        int max_val;
        bit busy;
        bit done;
        bit err;
    } expect_t;

    expect_t exp_q[$];
    expect_t cur;

    int total       = 0;
    int bad         = 0;
    int cycle_no    = 0;
    int rst_pulses  = 0;
    int done_pulses = 0;
    int done_cycle  = -1;
    int mc_cycles   = 0;
    int mc_first    = -1;
    int se_edge     = -1;

    int m_max = 0;
    bit m_err = 1'b0;

    bit sw_valid[$];
    int sw_data[$];

    peak_detector #(
        .W(W),
        .HYST(HYST),
        .RET_TIMEOUT(RET_TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .START(START),
        .ADC_VALID(ADC_VALID),
        .ADC_DATA(ADC_DATA),
        .SWEEP_END(SWEEP_END),
        .CNT_RU(CNT_RU),
        .CNT_RST(CNT_RST),
        .MC(MC),
        .MAX_VAL(MAX_VAL),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle_no, act, req);
        end
    endtask

    function automatic bit rnd(input bit noise);
        return noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic applyStimulus(input bit start, input bit valid, input logic [W-1:0] data,
                                 input bit send, input bit ru, input bit rst);
        @(negedge CLK);
        START     = start;
        ADC_VALID = valid;
        ADC_DATA  = data;
        SWEEP_END = send;
        CNT_RU    = ru;
        RESET     = rst;
    endtask

    task automatic pushExpect(input bit cr, input bit mc, input int mx,
                              input bit busy, input bit done, input bit err);
        expect_t e;
        e.cnt_rst = cr;
        e.mc      = mc;
        e.max_val = mx;
        e.busy    = busy;
        e.done    = done;
        e.err     = err;
        exp_q.push_back(e);
    endtask

    // Per-cycle checker: samples just after each rising edge and compares
    // against the next queued expectation; also gathers pulse statistics.
    always @(posedge CLK) begin
        #1;
        cycle_no++;
        if (CNT_RST === 1'b1) rst_pulses++;
        if (DONE === 1'b1) begin
            done_pulses++;
            done_cycle = cycle_no;
        end
        if (MC === 1'b1) begin
            mc_cycles++;
            if (mc_first < 0) mc_first = cycle_no;
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checkOutput("cnt_rst", 32'(CNT_RST), 32'(cur.cnt_rst));
            checkOutput("mc", 32'(MC), 32'(cur.mc));
            checkOutput("max_val", 32'(MAX_VAL), cur.max_val);
            checkOutput("busy", 32'(BUSY), 32'(cur.busy));
            checkOutput("done", 32'(DONE), 32'(cur.done));
            checkOutput("err", 32'(ERR), 32'(cur.err));
            checkOutput("mc_cnt_rst_overlap", 32'(MC & CNT_RST), 32'd0);
        end
    end

    // Runaway guard.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One calibration session: START, the queued sweep, the return run with
    // CNT_RU high for ru_len RET_WAIT cycles, then a few idle cycles.
    // abort_at >= 0 applies RESET on that sweep cycle instead.
    task automatic runSession(input int ru_len, input int abort_at, input bit noise);
        bit first_flag;
        bit acc;
        bit last;
        bit ru;
        bit aborted;
        int d;
        rst_pulses  = 0;
        done_pulses = 0;
        done_cycle  = -1;
        mc_cycles   = 0;
        mc_first    = -1;
        se_edge     = -1;
        aborted     = 1'b0;

        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        m_max      = 0;
        m_err      = 1'b0;
        first_flag = 1'b1;
        pushExpect(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < sw_valid.size(); i++) begin
            last = (i == sw_valid.size() - 1);
            d    = sw_data[i];
            if (i == abort_at) begin
                applyStimulus(rnd(noise), sw_valid[i], W'(d), 1'b0, rnd(noise), 1'b1);
                m_max   = 0;
                m_err   = 1'b0;
                aborted = 1'b1;
                pushExpect(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
                break;
            end
            applyStimulus(rnd(noise), sw_valid[i], W'(d), last, rnd(noise), 1'b0);
            acc = sw_valid[i] && (first_flag || d > m_max + HYST);
            if (acc) begin
                m_max      = d;
                first_flag = 1'b0;
            end
            if (last) se_edge = cycle_no + 1;
            pushExpect(acc, last && !acc, m_max, 1'b1, 1'b0, m_err);
        end

        if (!aborted) begin
            // RET_ARM: inputs other than the ones that matter are noise.
            applyStimulus(rnd(noise), rnd(noise), W'($urandom), rnd(noise), rnd(noise), 1'b0);
            pushExpect(1'b0, 1'b1, m_max, 1'b1, 1'b0, m_err);
            // RET_WAIT: a stray START on the first cycle must be ignored.
            for (int k = 0; k < RET_TIMEOUT; k++) begin
                ru = (k < ru_len);
                applyStimulus(noise ? rnd(noise) : (k == 0), rnd(noise), W'($urandom),
                              rnd(noise), ru, 1'b0);
                if (!ru) begin
                    pushExpect(1'b0, 1'b0, m_max, 1'b1, 1'b1, m_err);
                    break;
                end
                if (k == RET_TIMEOUT - 1) begin
                    m_err = 1'b1;
                    pushExpect(1'b0, 1'b0, m_max, 1'b1, 1'b1, 1'b1);
                    break;
                end
                pushExpect(1'b0, 1'b1, m_max, 1'b1, 1'b0, m_err);
            end
            // FIN: START here is ignored too.
            applyStimulus(rnd(noise), rnd(noise), W'($urandom), rnd(noise), rnd(noise), 1'b0);
            pushExpect(1'b0, 1'b0, m_max, 1'b0, 1'b0, m_err);
        end

        repeat (3) begin
            applyStimulus(1'b0, rnd(noise), W'($urandom), rnd(noise), rnd(noise), 1'b0);
            pushExpect(1'b0, 1'b0, m_max, 1'b0, 1'b0, m_err);
        end
    endtask

    task automatic buildRandomSweep();
        int n;
        n = $urandom_range(1, 12);
        sw_valid.delete();
        sw_data.delete();
        for (int i = 0; i < n; i++) begin
            sw_valid.push_back($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) sw_data.push_back($urandom_range(240, 255));
            else sw_data.push_back($urandom_range(0, 255));
        end
    endtask

    initial begin
        int abort_at;

        // Reset state.
        repeat (2) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            pushExpect(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        pushExpect(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Basic sweep with hysteresis, then a 5-cycle return run.
        sw_valid = '{1, 1, 1, 1, 1, 1, 0};
        sw_data  = '{10, 11, 13, 40, 41, 20, 0};
        runSession(5, -1, 1'b0);
        checkOutput("basic_cnt_rst_pulses", rst_pulses, 4);
        checkOutput("basic_max_val", 32'(MAX_VAL), 40);
        checkOutput("basic_mc_rise", mc_first, se_edge);
        checkOutput("basic_done_pulses", done_pulses, 1);
        checkOutput("basic_mc_cycles", mc_cycles, 7);
        checkOutput("basic_err", 32'(ERR), 0);

        // Peak at the end of the sweep: CNT_RU never rises.
        sw_valid = '{1, 1, 1, 0};
        sw_data  = '{5, 30, 90, 0};
        runSession(0, -1, 1'b0);
        checkOutput("peak_end_done_latency", done_cycle - se_edge + 1, 3);
        checkOutput("peak_end_done_pulses", done_pulses, 1);

        // Saturation (255 rejected after 254) and return timeout.
        sw_valid = '{1, 1, 0};
        sw_data  = '{254, 255, 0};
        runSession(RET_TIMEOUT + 5, -1, 1'b0);
        checkOutput("sat_max_val", 32'(MAX_VAL), 254);
        checkOutput("sat_err", 32'(ERR), 1);
        checkOutput("sat_mc_cycles", mc_cycles, 16);

        // New peak on the SWEEP_END cycle; START also clears the old ERR.
        sw_valid = '{1, 1};
        sw_data  = '{100, 200};
        runSession(0, -1, 1'b0);
        checkOutput("simul_max_val", 32'(MAX_VAL), 200);
        checkOutput("simul_cnt_rst_pulses", rst_pulses, 3);
        checkOutput("simul_err_cleared", 32'(ERR), 0);

        // Abort mid-sweep with MAX_VAL=77.
        sw_valid = '{1, 1, 1};
        sw_data  = '{77, 10, 5};
        runSession(0, 2, 1'b0);
        checkOutput("abort_max_val", 32'(MAX_VAL), 0);
        checkOutput("abort_busy", 32'(BUSY), 0);
        checkOutput("abort_mc", 32'(MC), 0);
        checkOutput("abort_done_pulses", done_pulses, 0);

        // Randomized sessions with noise on ignored inputs.
        for (int s = 0; s < 40; s++) begin
            buildRandomSweep();
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, sw_valid.size() - 1)) : -1;
            runSession($urandom_range(0, RET_TIMEOUT + 5), abort_at, 1'b1);
        end

        @(posedge CLK);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peak_detector.md
Name: peak_detector

Overview:
- Calibration-side partner of the max counter in the solar-tracker ADC path.
- Tracks the peak ADC reading during a servo sweep and pulses CNT_RST each time a new maximum is captured.
- At end of sweep, asserts MC so the max counter counts back down.
- Watches CNT_RU until the return run completes, then reports DONE to the tracking FSM.

Parameters:
- W, 8, ADC sample width in bits.
- HYST, 2, minimum margin by which a sample must exceed the stored max to count as a new max.
- RET_TIMEOUT, 1023, maximum cycles allowed in RET_WAIT before flagging ERR (counter width = clog2(RET_TIMEOUT+1)).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous active-high reset.
- START  in  1  begin a calibration sweep; sampled only in IDLE.
- ADC_VALID  in  1  ADC_DATA holds a new sample this cycle.
- ADC_DATA  in  W  unsigned ADC sample.
- SWEEP_END  in  1  horizontal/vertical counter reached end of sweep (level or pulse).
- CNT_RU  in  1  max-counter return-in-progress flag.
- CNT_RST  out  1  one-cycle pulse that clears the max counter.
- MC  out  1  max-counter direction: 0 = count up, 1 = count down.
- MAX_VAL  out  W  stored peak sample.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the return completes.
- ERR  out  1  sticky return-timeout flag; cleared on START or RESET.

Behaviour:
- Interface: one clock, CLK. Reset RESET is synchronous and active-high.
- All outputs are registered.
- RESET values: state=IDLE; CNT_RST=0, MC=0, MAX_VAL=0, BUSY=0, DONE=0, ERR=0; first-sample flag set; timeout counter 0.
- RESET mid-operation aborts immediately to these values. No DONE is produced.
- States: IDLE, SWEEP, RET_ARM, RET_WAIT, FIN.
- IDLE:
  - MC=0, BUSY=0.
  - START=1 -> next cycle: state SWEEP, MAX_VAL=0, first-flag=1, ERR=0, CNT_RST=1 for exactly that one cycle (clears the max counter).
- SWEEP:
  - On ADC_VALID, a sample is accepted if first-flag=1, or if ADC_DATA > MAX_VAL + HYST.
  - The comparison is done at W+1 bits so MAX_VAL+HYST never wraps. If MAX_VAL+HYST >= 2^W, no later sample is accepted.
  - On accept: MAX_VAL<=ADC_DATA, first-flag<=0, CNT_RST=1 on the following cycle (latency 1, one cycle wide).
  - Samples arriving back-to-back each generate their own pulse.
- SWEEP_END in SWEEP -> RET_ARM.
  - If ADC_VALID coincides with SWEEP_END, that sample is still evaluated and may update MAX_VAL and pulse CNT_RST.
  - MC rises in the cycle after SWEEP_END.
- RET_ARM:
  - Exactly one cycle, MC=1. This absorbs the one-cycle lag of CNT_RU.
  - -> RET_WAIT. Timeout counter cleared.
- RET_WAIT:
  - MC=1. ADC_VALID is ignored and MAX_VAL is frozen.
  - CNT_RU=0 -> FIN. If the peak was at the end of the sweep, CNT_RU never rises and FIN is reached after the first RET_WAIT cycle.
  - Otherwise the counter increments each cycle. On reaching RET_TIMEOUT: ERR<=1 -> FIN.
- FIN:
  - DONE=1 for one cycle, MC<=0 -> IDLE.
  - MAX_VAL held until the next START or RESET.
- Ignored inputs:
  - START outside IDLE.
  - SWEEP_END outside SWEEP.
- CNT_RST is never asserted outside the START cycle and SWEEP accepts.
- MC and CNT_RST are never high in the same cycle.

Test Plan:
- Basic: RESET then START, samples 10, 11, 13, 40, 41, 20, then SWEEP_END. CNT_RST pulses after 10, 13 and 40 only (hysteresis 2; 11 and 41 rejected); MAX_VAL=40; MC=1 one cycle after SWEEP_END.
- Return: CNT_RU held 1 for 5 cycles after RET_ARM, then 0. DONE pulses once; MC falls with DONE; BUSY falls the following cycle; ERR=0.
- Peak at end: last sample is the max, CNT_RU stays 0. DONE appears 3 cycles after SWEEP_END (RET_ARM, RET_WAIT, FIN).
- Simultaneous: ADC_VALID=1 with ADC_DATA=200 on the same cycle as SWEEP_END, prior MAX_VAL=100. MAX_VAL=200, CNT_RST pulses, and the state still advances to RET_ARM.
- Saturation and timeout: samples 254 then 255 with W=8, HYST=2, so 255 is rejected; then CNT_RU held 1 with RET_TIMEOUT=15. ERR=1 and DONE pulse after 15 RET_WAIT cycles; next START clears ERR.
- Abort: RESET asserted mid-SWEEP with MAX_VAL=77. Next cycle shows IDLE, MAX_VAL=0, MC=0, BUSY=0, no DONE; START issued during RET_WAIT is ignored.
